// File: rtl/sid_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sid_pkg
//  Description : Shared types and constants for the SID amplitude-stage
//                scheduler and its shared multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
package sid_pkg;

  localparam int C_VOICE_W        = 12;  // voice waveform width
  localparam int C_ENV_W          = 8;   // envelope level width
  localparam int C_SAMPLE_W       = 16;  // mixed sample / product slice width
  localparam int C_A_SHIFT        = 4;   // voice pre-scale into the 16-bit A port
  localparam int C_MUL_A_W        = C_VOICE_W + C_A_SHIFT;
  localparam int C_HEADROOM_SHIFT = 2;   // per-voice attenuation before summing
  localparam int C_PROD_HI        = 23;  // top bit of the kept product slice
  localparam int C_PROD_LO        = 8;   // bottom bit of the kept product slice
  localparam int C_PROD_W         = C_PROD_HI + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL0  = 3'd1,
    ST_MUL1  = 3'd2,
    ST_MUL2  = 3'd3,
    ST_DRAIN = 3'd4
  } sched_state_t;

  // Offset-binary voice sample to two's complement: flip the MSB.
  function automatic logic signed [C_VOICE_W-1:0] voice_to_signed(
    input logic [C_VOICE_W-1:0] i_v
  );
    return {~i_v[C_VOICE_W-1], i_v[C_VOICE_W-2:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sid_mdac_mul.sv
`default_nettype none
// ============================================================================
//  Module      : sid_mdac_mul
//  Description : Registered signed(16) x unsigned(8) multiplier shared by the
//                three voices. Shaped to fit one SB_MAC16 (A signed, B
//                unsigned, registered output); exposes product bits [23:8].
//  Revision    : 1.0 - initial release
// ============================================================================
module sid_mdac_mul
  import sid_pkg::*;
(
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic signed [C_MUL_A_W-1:0]  i_a,
  input  logic        [C_ENV_W-1:0]    i_b,
  output logic signed [C_SAMPLE_W-1:0] o_p
);

  logic signed [C_PROD_W-1:0]   w_a_ext;
  logic signed [C_PROD_W-1:0]   w_b_ext;
  logic signed [C_PROD_W-1:0]   w_prod;
  logic signed [C_SAMPLE_W-1:0] r_p;

  // 24 bits hold every product exactly: |A*B| <= 32768*255 < 2^23.
  assign w_a_ext = {{(C_PROD_W - C_MUL_A_W){i_a[C_MUL_A_W-1]}}, i_a};
  assign w_b_ext = {{(C_PROD_W - C_ENV_W){1'b0}}, i_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // Product register: keeps the [23:8] slice, one cycle of latency.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_p <= '0;
    end else begin
      r_p <= C_SAMPLE_W'(w_prod >>> C_PROD_LO);
    end
  end

  assign o_p = r_p;

endmodule
`default_nettype wire

// File: rtl/sid_mdac_sched.sv
`default_nettype none
// ============================================================================
//  Module      : sid_mdac_sched
//  Description : Time-multiplexed amplitude stage for the three SID voices.
//                Each CLKen snapshots the voice/envelope pairs, runs them
//                through one shared multiplier and emits one mixed signed
//                sample with a VALID pulse five cycles later.
//                Optional feature macro: SID_MDAC_VOICE3OFF_EN (honour
//                VOICE3OFF by dropping voice 2 from the mix).
//  Revision    : 1.0 - initial release
// ============================================================================
module sid_mdac_sched
  import sid_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  CLKen,
  input  logic [C_VOICE_W-1:0]  VOICE0,
  input  logic [C_VOICE_W-1:0]  VOICE1,
  input  logic [C_VOICE_W-1:0]  VOICE2,
  input  logic [C_ENV_W-1:0]    ENV0,
  input  logic [C_ENV_W-1:0]    ENV1,
  input  logic [C_ENV_W-1:0]    ENV2,
  input  logic                  VOICE3OFF,
  output logic [C_SAMPLE_W-1:0] OUTPUT,
  output logic                  VALID,
  output logic                  BUSY,
  output logic                  OVERRUN
);

  sched_state_t r_state;
  sched_state_t w_state_nxt;

  logic                         w_start;
  logic                         w_acc_en;
  logic                         w_last;
  logic                         w_busy;

  logic signed [C_VOICE_W-1:0]  r_sv0, r_sv1, r_sv2;
  logic        [C_ENV_W-1:0]    r_e0, r_e1, r_e2;

  logic signed [C_MUL_A_W-1:0]  w_mul_a;
  logic        [C_ENV_W-1:0]    w_mul_b;
  logic signed [C_SAMPLE_W-1:0] w_p;
  logic signed [C_SAMPLE_W-1:0] w_p_sh;
  logic signed [C_SAMPLE_W-1:0] w_p_last;

  logic signed [C_SAMPLE_W-1:0] r_acc;
  logic        [C_SAMPLE_W-1:0] r_out;
  logic                         r_valid;
  logic                         r_ovr;

  // State register.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, multiplier operand select and datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_acc_en    = 1'b0;
    w_last      = 1'b0;
    w_busy      = 1'b1;
    w_mul_a     = '0;
    w_mul_b     = '0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (CLKen) begin
          w_start     = 1'b1;
          w_state_nxt = ST_MUL0;
        end
      end
      ST_MUL0: begin
        w_mul_a     = {r_sv0, {C_A_SHIFT{1'b0}}};
        w_mul_b     = r_e0;
        w_state_nxt = ST_MUL1;
      end
      ST_MUL1: begin
        w_mul_a     = {r_sv1, {C_A_SHIFT{1'b0}}};
        w_mul_b     = r_e1;
        w_acc_en    = 1'b1;   // p0 is out of the multiplier now
        w_state_nxt = ST_MUL2;
      end
      ST_MUL2: begin
        w_mul_a     = {r_sv2, {C_A_SHIFT{1'b0}}};
        w_mul_b     = r_e2;
        w_acc_en    = 1'b1;   // p1
        w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_last      = 1'b1;   // p2 goes straight into OUTPUT
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_busy      = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Snapshot registers: captured once per round so later input changes
  // cannot disturb a round in flight.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_sv0 <= '0;
      r_sv1 <= '0;
      r_sv2 <= '0;
      r_e0  <= '0;
      r_e1  <= '0;
      r_e2  <= '0;
    end else if (w_start) begin
      r_sv0 <= voice_to_signed(VOICE0);
      r_sv1 <= voice_to_signed(VOICE1);
      r_sv2 <= voice_to_signed(VOICE2);
      r_e0  <= ENV0;
      r_e1  <= ENV1;
      r_e2  <= ENV2;
    end
  end

  sid_mdac_mul u_mul (
    .i_clk   (CLK),
    .i_rst_n (RESETn),
    .i_a     (w_mul_a),
    .i_b     (w_mul_b),
    .o_p     (w_p)
  );

  assign w_p_sh = w_p >>> C_HEADROOM_SHIFT;

`ifdef SID_MDAC_VOICE3OFF_EN
  logic r_voff;

  // Mute flag is part of the snapshot, like the voice/envelope pairs.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_voff <= 1'b0;
    end else if (w_start) begin
      r_voff <= VOICE3OFF;
    end
  end

  // The MUL2 slot still runs; only its contribution is dropped.
  assign w_p_last = r_voff ? '0 : w_p_sh;
`else
  logic w_unused_voff;
  assign w_unused_voff = VOICE3OFF;
  assign w_p_last      = w_p_sh;
`endif

  // Accumulator: cleared on the snapshot cycle, sums p0 and p1. Three
  // attenuated products stay within +/-24480, so no saturation is needed.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_acc <= '0;
    end else if (w_start) begin
      r_acc <= '0;
    end else if (w_acc_en) begin
      r_acc <= r_acc + w_p_sh;
    end
  end

  // Output sample and its one-cycle VALID pulse.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_last;
      if (w_last) begin
        r_out <= r_acc + w_p_last;
      end
    end
  end

  // Sticky overrun: any strobe arriving while a round is in progress,
  // including the DRAIN cycle, is dropped and flagged.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_ovr <= 1'b0;
    end else if (CLKen && w_busy) begin
      r_ovr <= 1'b1;
    end
  end

  assign OUTPUT  = r_out;
  assign VALID   = r_valid;
  assign BUSY    = w_busy;
  assign OVERRUN = r_ovr;

endmodule
`default_nettype wire

// File: doc/sid_mdac_sched.md
# sid_mdac_sched

Time-multiplexed scheduler for the SID voice amplitude stage. One shared registered 12x8 multiplier replaces the three per-voice multiplying DACs. On each 1 MHz `CLKen` strobe the block snapshots the three voice/envelope pairs and sequences them through the multiplier. It accumulates the headroom-shifted products and presents one mixed signed 16-bit sample with a valid pulse. It sits between the `sid_voice`/`sid_env` instances and the audio output path.

## Interface
- No parameters.
- `CLK` in 1: master clock.
- `RESETn` in 1: reset, active-low, synchronous.
- `CLKen` in 1: 1 MHz enable; starts a mix round.
- `VOICE0`, `VOICE1`, `VOICE2` in 12 each: voice waveform outputs, offset-binary.
- `ENV0`, `ENV1`, `ENV2` in 8 each: envelope levels, unsigned.
- `VOICE3OFF` in 1: mutes voice 2 from the mix. Only used when the macro below is defined.
- `OUTPUT` out 16: signed mixed sample.
- `VALID` out 1: one-cycle pulse when `OUTPUT` updates.
- `BUSY` out 1: high while a round is in progress.
- `OVERRUN` out 1: sticky flag, set when a `CLKen` is dropped.

## Operation
- States: IDLE, MUL0, MUL1, MUL2, DRAIN.
- IDLE, `CLKen`=1:
  - Snapshot all six inputs (plus `VOICE3OFF`) into registers.
  - Clear the accumulator.
  - Go to MUL0.
- MUL0 / MUL1 / MUL2: issue snapshot pair 0 / 1 / 2 to the multiplier. Advance one state per cycle.
- DRAIN: accumulate the last product, then return to IDLE.
- Operand conversion:
  - Voice: signed12 = {~v[11], v[10:0]}.
  - Multiplier A input: signed12 << 4.
  - Multiplier B input: envelope zero-extended.
- Product `p` = (A*B)[23:8], signed 16-bit.
- Accumulator: 16-bit signed, acc += p >>> 2.
  - Worst case is ±3*8160 (-24480 to +24468), so overflow is impossible and there is no saturation.
- On the last accumulate: `OUTPUT` <= acc + p2 >>> 2, and `VALID` pulses.
- `CLKen` while `BUSY`=1:
  - The strobe is ignored and `OVERRUN` is set.
  - `OVERRUN` is cleared only by reset.
  - `CLKen` in the same cycle the FSM returns to IDLE counts as busy.
- Inputs changing after the snapshot cycle have no effect on the current round.

## Timing
- Define cycle k as the cycle in which `CLKen` is sampled high in IDLE.
- Cycle k+1 (MUL0): pair 0 at the multiplier.
- Cycle k+2 (MUL1): pair 1 issued; p0 valid and accumulated.
- Cycle k+3 (MUL2): pair 2 issued; p1 accumulated.
- Cycle k+4 (DRAIN): p2 accumulated.
- Cycle k+5:
  - `OUTPUT` holds the new sample and `VALID`=1 for exactly this cycle.
  - FSM is in IDLE, and a new `CLKen` is accepted in this cycle.
- `BUSY` is high in cycles k+1 through k+4.
- Multiplier latency is fixed at 1 cycle (product registered).
- Reset values: state IDLE, `OUTPUT`=0, `VALID`=0, `BUSY`=0, `OVERRUN`=0, accumulator 0.
- Reset asserted mid-round aborts the round: no `VALID`, and `OUTPUT` returns to 0.

## Configuration
- Macro: `SID_MDAC_VOICE3OFF_EN`.
- Defined: when the snapshot of `VOICE3OFF` is 1, the p2 contribution is forced to 0. Cycle timing and the MUL2 slot are unchanged.
- Undefined: `VOICE3OFF` is ignored and all three voices are always summed.

## Structure
- Shared package `sid_pkg`:
  - State enum.
  - Width constants: voice 12, env 8, sample 16.
  - Headroom shift constant = 2.
  - Product slice constants [23:8].
- One sub-module, `sid_mdac_mul`:
  - Registered signed x unsigned multiply.
  - Maps to SB_MAC16: A signed, B unsigned, 16x16 registered output.
  - Exposes the [23:8] slice.
- Scheduler FSM, snapshot registers and accumulator live in `sid_mdac_sched`.

## Test plan
- VOICE0=0xFFF, ENV0=0xFF, VOICE1=VOICE2=0x800, ENV1=ENV2=0xFF, `CLKen` at k -> `OUTPUT`=8156 and `VALID`=1 at k+5 only; `BUSY` high k+1 to k+4.
- All voices 0x000, all envs 0xFF -> `OUTPUT`=-24480. All voices 0xFFF, all envs 0xFF -> `OUTPUT`=24468.
- Macro defined, all voices 0xFFF, envs 0xFF, `VOICE3OFF`=1 -> `OUTPUT`=16312. Macro undefined, same stimulus -> `OUTPUT`=24468.
- `CLKen` at k and k+2 -> a single `VALID` at k+5, `OVERRUN`=1 from k+3, `OUTPUT` from the first snapshot only.
- Inputs changed to 0x800 at k+1 after a full-scale snapshot -> `OUTPUT` still 24468.
- `RESETn` low during k+2 -> no `VALID`, `OUTPUT`=0, state IDLE; the next `CLKen` completes normally.
